// File: rtl/fb_arb_pkg.sv
// ============================================================================
// Module  : fb_arb_pkg
// Brief   : Shared types and default constants for the frame-buffer arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_arb_pkg;

  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_BURST_MAX  = 16;
  localparam int DEF_STARVE_LIM = 1023;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VGA_OWN = 2'd1,
    ST_CNN_OWN = 2'd2,
    ST_CNN_GAP = 2'd3
  } owner_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CNN  = 2'd2
  } rd_tag_e;

endpackage

`default_nettype wire

// File: rtl/fb_rd_tag_pipe.sv
// ============================================================================
// Module  : fb_rd_tag_pipe
// Brief   : Owner-tag delay line matching the frame-buffer read latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rd_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_e tag_i,
  output rd_tag_e tag_o
);

  rd_tag_e stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fb_read_arbiter.sv
// ============================================================================
// Module  : fb_read_arbiter
// Brief   : VGA-priority read arbiter for frame-buffer port B with bursted CNN
//           access. Starvation monitor and statistics exist only when
//           FB_ARB_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cnn_req,
  input  logic [ADDR_W-1:0] cnn_addr,
  output logic              cnn_gnt,
  output logic              cnn_rvalid,
  output logic [DATA_W-1:0] cnn_rdata,
  output logic              cnn_starved,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [31:0]       stat_cnn_words,
  output logic [15:0]       stat_preempt
);

  localparam int         PIPE_DEPTH = 1 + RD_LAT;
  localparam logic [4:0] BURST_LAST = 5'(BURST_MAX - 1);

  if (RD_LAT < 1 || RD_LAT > 3 || BURST_MAX < 1 || BURST_MAX > 31 ||
      STARVE_LIM < 1 || STARVE_LIM > 2047) begin : g_param_check
    $error("fb_read_arbiter: parameter out of range");
  end

  owner_state_e      state_q, state_d;
  logic [4:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              gnt_raw;
  rd_tag_e           tag_in, tag_out;
  logic              vga_valid, cnn_valid;
  logic [DATA_W-1:0] vga_hold_q, cnn_hold_q;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    fb_addr_d = fb_addr_q;
    gnt_raw   = 1'b0;
    tag_in    = TAG_NONE;
    if (vga_req) begin
      state_d   = ST_VGA_OWN;
      burst_d   = '0;
      fb_addr_d = vga_addr;
      tag_in    = TAG_VGA;
    end else if (cnn_req && state_q != ST_CNN_GAP) begin
      gnt_raw   = 1'b1;
      fb_addr_d = cnn_addr;
      tag_in    = TAG_CNN;
      if (burst_q == BURST_LAST) begin
        state_d = ST_CNN_GAP;
        burst_d = '0;
      end else begin
        state_d = ST_CNN_OWN;
        burst_d = burst_q + 5'd1;
      end
    end else begin
      state_d = ST_IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      fb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      fb_addr_q <= fb_addr_d;
    end
  end

  assign cnn_gnt = gnt_raw & ~rst;
  assign fb_addr = fb_addr_q;

  fb_rd_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk   (clk25),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Gating with rst also drops the read that would surface during the reset cycle.
  assign vga_valid  = (tag_out == TAG_VGA) && !rst;
  assign cnn_valid  = (tag_out == TAG_CNN) && !rst;
  assign vga_rvalid = vga_valid;
  assign cnn_rvalid = cnn_valid;
  assign vga_rdata  = vga_valid ? fb_rdata : vga_hold_q;
  assign cnn_rdata  = cnn_valid ? fb_rdata : cnn_hold_q;

  always_ff @(posedge clk25) begin
    if (rst) begin
      vga_hold_q <= '0;
      cnn_hold_q <= '0;
    end else begin
      if (vga_valid) vga_hold_q <= fb_rdata;
      if (cnn_valid) cnn_hold_q <= fb_rdata;
    end
  end

`ifdef FB_ARB_STATS_EN
  localparam logic [10:0] STARVE_THR = 11'(STARVE_LIM);

  logic [10:0] wait_q;
  logic [31:0] words_q;
  logic [15:0] preempt_q;
  logic        preempt;

  assign preempt = vga_req && (state_q == ST_CNN_OWN) && (burst_q != '0);

  always_ff @(posedge clk25) begin
    if (rst) begin
      wait_q    <= '0;
      words_q   <= '0;
      preempt_q <= '0;
    end else begin
      if (!cnn_req || cnn_gnt) wait_q <= '0;
      else if (wait_q != '1)   wait_q <= wait_q + 11'd1;
      if (cnn_gnt) words_q   <= words_q + 32'd1;
      if (preempt) preempt_q <= preempt_q + 16'd1;
    end
  end

  assign cnn_starved    = (wait_q >= STARVE_THR);
  assign stat_cnn_words = words_q;
  assign stat_preempt   = preempt_q;
`else
  assign cnn_starved    = 1'b0;
  assign stat_cnn_words = '0;
  assign stat_preempt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_read_arbiter.sv
// ============================================================================
// Module  : tb_fb_read_arbiter
// Brief   : Self-checking bench for fb_read_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_read_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int RD_LAT     = 1;
  localparam int BURST_MAX  = 16;
  localparam int STARVE_LIM = 1023;
`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk25 = 1'b0;
  logic              rst, vga_req, cnn_req;
  logic [ADDR_W-1:0] vga_addr, cnn_addr, fb_addr;
  logic              vga_rvalid, cnn_gnt, cnn_rvalid, cnn_starved;
  logic [DATA_W-1:0] vga_rdata, cnn_rdata;
  logic [DATA_W-1:0] fb_rdata = '0;
  logic [31:0]       stat_cnn_words;
  logic [15:0]       stat_preempt;

  fb_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .BURST_MAX(BURST_MAX), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk25(clk25), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cnn_req(cnn_req), .cnn_addr(cnn_addr), .cnn_gnt(cnn_gnt), .cnn_rvalid(cnn_rvalid),
    .cnn_rdata(cnn_rdata), .cnn_starved(cnn_starved), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .stat_cnn_words(stat_cnn_words), .stat_preempt(stat_preempt)
  );

  always #20 clk25 = ~clk25;

  function automatic logic [DATA_W-1:0] fbmem(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = a ^ (a >> 7);
    return m[DATA_W-1:0] ^ 12'h5A3;
  endfunction

  // Frame buffer with a single registered read stage (RD_LAT = 1).
  always @(posedge clk25) fb_rdata <= fbmem(fb_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int                due;
    bit                is_vga;
    logic [DATA_W-1:0] data;
  } rd_t;

  rd_t               q[$];
  int                cyc = 0;
  logic [ADDR_W-1:0] m_fb = '0;
  int                m_run = 0;
  bit                m_gap = 1'b0;
  int                m_wait = 0;
  logic [31:0]       m_words = '0;
  logic [15:0]       m_pre = '0;
  logic [DATA_W-1:0] m_vdat = '0, m_cdat = '0;

  int n_vrv = 0, n_crv = 0, n_gnt = 0;
  int first_vrv = -1, starve_rise = -1;
  bit prev_starved = 1'b0;

  always @(negedge clk25) begin
    logic e_gnt, e_vrv, e_crv;
    e_gnt = !rst && !vga_req && cnn_req && !m_gap;
    e_vrv = 1'b0;
    e_crv = 1'b0;
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      if (q[0].is_vga) begin e_vrv = 1'b1; m_vdat = q[0].data; end
      else             begin e_crv = 1'b1; m_cdat = q[0].data; end
      void'(q.pop_front());
    end
    if (cyc > 0) begin
      check("cnn_gnt", cnn_gnt, e_gnt);
      check("fb_addr", fb_addr, m_fb);
      check("vga_rvalid", vga_rvalid, e_vrv);
      check("cnn_rvalid", cnn_rvalid, e_crv);
      check("vga_rdata", vga_rdata, m_vdat);
      check("cnn_rdata", cnn_rdata, m_cdat);
      check("cnn_starved", cnn_starved, STATS && (m_wait >= STARVE_LIM));
      check("stat_cnn_words", stat_cnn_words, STATS ? m_words : 32'd0);
      check("stat_preempt", stat_preempt, STATS ? m_pre : 16'd0);
      if (vga_rvalid) begin
        n_vrv++;
        if (first_vrv < 0) first_vrv = cyc;
      end
      if (cnn_rvalid) n_crv++;
      if (cnn_gnt) n_gnt++;
      if (cnn_starved && !prev_starved) starve_rise = cyc;
      prev_starved = cnn_starved;
    end
    // advance the model across the coming clock edge
    if (rst) begin
      m_fb = '0; m_run = 0; m_gap = 1'b0; m_wait = 0;
      m_words = '0; m_pre = '0; m_vdat = '0; m_cdat = '0;
      q.delete();
    end else begin
      if (vga_req) begin
        if (m_run > 0) m_pre = m_pre + 16'd1;
        m_run = 0; m_gap = 1'b0; m_fb = vga_addr;
        q.push_back('{due: cyc + 1 + RD_LAT, is_vga: 1'b1, data: fbmem(vga_addr)});
      end else if (e_gnt) begin
        m_fb = cnn_addr;
        m_words = m_words + 32'd1;
        q.push_back('{due: cyc + 1 + RD_LAT, is_vga: 1'b0, data: fbmem(cnn_addr)});
        m_run++;
        m_gap = (m_run == BURST_MAX);
        if (m_gap) m_run = 0;
      end else begin
        m_run = 0; m_gap = 1'b0;
      end
      if (cnn_req && !e_gnt) m_wait = (m_wait < 2047) ? m_wait + 1 : 2047;
      else                   m_wait = 0;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  int p1, ps, g0, c0, v0;

  initial begin
    rst = 1'b1; vga_req = 1'b0; cnn_req = 1'b0; vga_addr = '0; cnn_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    #2;
    check("reset_fb_addr", fb_addr, 0);
    check("reset_vga_rdata", vga_rdata, 0);
    check("reset_rvalids", {vga_rvalid, cnn_rvalid, cnn_starved}, 0);
    check("reset_stats", {stat_cnn_words, stat_preempt}, 0);
    tick();

    // Continuous VGA scan of 640 pixels.
    p1 = cyc;
    for (int n = 0; n < 640; n++) begin
      vga_req = 1'b1; vga_addr = ADDR_W'(n); cnn_req = (n >= 600);
      tick();
    end
    vga_req = 1'b0; cnn_req = 1'b0;
    repeat (4) tick();
    check("p1_vga_rvalid_count", n_vrv, 640);
    check("p1_first_rvalid_lag", first_vrv - p1, 2);
    check("p1_no_grants", n_gnt, 0);

    // CNN-only, 40 cycles: 16 grants, gap, 16 grants, gap, 6 grants.
    g0 = n_gnt; c0 = n_crv;
    for (int n = 0; n < 40; n++) begin
      cnn_req = 1'b1; cnn_addr = ADDR_W'(32'h100 + n);
      if (n == 15 || n == 16 || n == 17 || n == 33 || n == 34) begin
        #2;
        check("p2_burst_pattern", cnn_gnt, (n == 16 || n == 33) ? 1'b0 : 1'b1);
      end
      tick();
    end
    cnn_req = 1'b0;
    repeat (4) tick();
    check("p2_grants", n_gnt - g0, 38);
    check("p2_cnn_rvalid_count", n_crv - c0, 38);
    check("p2_model_words", m_words, 38);
    check("p2_stat_words", stat_cnn_words, STATS ? 38 : 0);

    // VGA preempts a CNN burst after 5 words.
    g0 = n_gnt; c0 = n_crv; v0 = n_vrv;
    for (int n = 0; n < 5; n++) begin
      cnn_req = 1'b1; cnn_addr = ADDR_W'(32'h300 + n);
      tick();
    end
    vga_req = 1'b1; vga_addr = ADDR_W'(32'h4000);
    #2;
    check("p3_gnt_blocked_by_vga", cnn_gnt, 0);
    tick();
    for (int k = 1; k < 3; k++) begin
      vga_addr = ADDR_W'(32'h4000 + k);
      tick();
    end
    vga_req = 1'b0; cnn_req = 1'b0;
    repeat (4) tick();
    check("p3_grants", n_gnt - g0, 5);
    check("p3_cnn_rvalid_count", n_crv - c0, 5);
    check("p3_vga_rvalid_count", n_vrv - v0, 3);
    check("p3_model_preempt", m_pre, 1);
    check("p3_stat_preempt", stat_preempt, STATS ? 1 : 0);

    // Starvation: both request for 1100 cycles.
    ps = cyc; g0 = n_gnt;
    for (int n = 0; n < 1100; n++) begin
      vga_req = 1'b1; vga_addr = ADDR_W'(32'h6000 + n);
      cnn_req = 1'b1; cnn_addr = ADDR_W'(32'h500);
      tick();
    end
    vga_req = 1'b0;
    #2;
    check("p4_starved_held", cnn_starved, STATS);
    check("p4_gnt_after_vga", cnn_gnt, 1);
    tick();
    cnn_req = 1'b0;
    #2;
    check("p4_starved_cleared", cnn_starved, 0);
    repeat (4) tick();
    check("p4_starve_rise", STATS ? (starve_rise - ps) : starve_rise, STATS ? 1023 : -1);
    check("p4_grants", n_gnt - g0, 1);
    check("p4_stat_words", stat_cnn_words, STATS ? 44 : 0);

    // Reset with two VGA reads in flight.
    v0 = n_vrv;
    vga_req = 1'b1; vga_addr = ADDR_W'(32'h7000); tick();
    vga_addr = ADDR_W'(32'h7001); tick();
    vga_req = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    #2;
    check("p5_outputs_zero",
          {vga_rvalid, cnn_rvalid, cnn_gnt, cnn_starved, vga_rdata, cnn_rdata, fb_addr}, 0);
    check("p5_stats_zero", {stat_cnn_words, stat_preempt}, 0);
    repeat (5) tick();
    check("p5_no_rvalid_after_reset", n_vrv - v0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
